// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle unsigned MULTU/DIVU engine with internal HI/LO.
// Sits beside the single-cycle ALU in EX. The pipeline stalls on busy.
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   start, Signal   operation request and 6-bit funct code
//   dataA, dataB    multiplicand/dividend and multiplier/divisor
//   busy, done      operation in flight / one-cycle completion pulse
//   hi, lo          result registers
//   dataOut         combinational MFHI/MFLO read-back (0 for other codes)
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] dataOut
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // acc holds {product high, multiplier/product low} for MUL and
  // {remainder, quotient} for DIV; op_q is the multiplicand or divisor.
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d;
  logic             last_iter;

  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_acc;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic [AW-1:0]    div_acc;

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Shift-add step: carry out of the upper-half add becomes the new MSB.
  always_comb begin
    mul_sum = {1'b0, acc_q[AW-1:WIDTH]};
    if (acc_q[0]) begin
      mul_sum = mul_sum + {1'b0, op_q};
    end
    mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Restoring divide step; the trial remainder is one bit wider because the
  // left shift of a remainder close to a large divisor can exceed WIDTH bits.
  always_comb begin
    div_trial = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, op_q};
    if (div_trial >= {1'b0, op_q}) begin
      div_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi;
    lo_d    = lo;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && (Signal == MULTU)) begin
          state_d = MUL;
          acc_d   = {{WIDTH{1'b0}}, dataB};
          op_d    = dataA;
          cnt_d   = '0;
        end else if (start && (Signal == DIVU)) begin
          state_d = DIV;
          acc_d   = {{WIDTH{1'b0}}, dataA};
          op_d    = dataB;
          cnt_d   = '0;
        end
      end
      MUL: begin
        acc_d = mul_acc;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = DONE;
          hi_d    = mul_acc[AW-1:WIDTH];
          lo_d    = mul_acc[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = DONE;
          hi_d    = div_acc[AW-1:WIDTH];
          lo_d    = div_acc[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == MUL) || (state_d == DIV);
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // MFHI/MFLO read-back port.
  always_comb begin
    dataOut = '0;
    if (Signal == MFHI) begin
      dataOut = hi;
    end else if (Signal == MFLO) begin
      dataOut = lo;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int unsigned W = 32;
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] DIVU  = 6'd27;
  localparam logic [5:0] MFHI  = 6'd16;
  localparam logic [5:0] MFLO  = 6'd18;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   Signal;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] dataOut;

  int   tests = 0;
  int   fails = 0;
  res_t sb[$];
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .dataOut (dataOut)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Completion monitor: every done pulse retires one scoreboard entry.
  always @(negedge clk) begin
    res_t r;
    if (done) begin
      check("done_single_cycle", W'(prev_done), W'(0));
      if (sb.size() == 0) begin
        check("unexpected_done", W'(done), W'(0));
      end else begin
        r = sb.pop_front();
        check("hi", hi, r.hi);
        check("lo", lo, r.lo);
      end
    end
    prev_done <= done;
  end

  // Caller sits at a negedge; start is held across exactly one rising edge.
  task automatic issue(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] eh, input logic [W-1:0] el);
    start  = 1'b1;
    Signal = sig;
    dataA  = a;
    dataB  = b;
    if (push) sb.push_back({eh, el});
    @(posedge clk);
    #1;
    start  = 1'b0;
    Signal = MFLO;
  endtask

  // Returns the cycle index of the done pulse and the busy cycles before it.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
    if (lat == 0) check("done_timeout", W'(0), W'(1));
  endtask

  int lat;
  int bcnt;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    Signal = MFLO;
    dataA  = '0;
    dataB  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_hi", hi, W'(0));
    check("rst_lo", lo, W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));

    // 7 x 6
    issue(MULTU, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42);
    check("mul_busy_after_start", W'(busy), W'(1));
    wait_done(lat, bcnt);
    check("mul_latency", W'(lat), W'(33));
    check("mul_busy_cycles", W'(bcnt), W'(32));
    check("mul_done_busy_low", W'(busy), W'(0));
    check("mflo_42", dataOut, 32'd42);
    Signal = DIVU;
    #1;
    check("dataout_other", dataOut, W'(0));
    Signal = MFLO;

    // Full-scale multiply exercises the carry out of the upper add.
    @(negedge clk);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done(lat, bcnt);
    check("mul_max_latency", W'(lat), W'(33));

    @(negedge clk);
    issue(DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    wait_done(lat, bcnt);
    check("div_latency", W'(lat), W'(33));
    check("div_busy_cycles", W'(bcnt), W'(32));

    // Divide by zero.
    @(negedge clk);
    issue(DIVU, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    Signal = MFHI;
    #1;
    check("mfhi_div0", dataOut, 32'h1234_5678);
    Signal = MFLO;

    // start during MUL is ignored; MFHI while busy shows the previous HI.
    @(negedge clk);
    issue(MULTU, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15);
    repeat (4) @(negedge clk);
    Signal = MFHI;
    #1;
    check("mfhi_during_busy", dataOut, 32'h1234_5678);
    check("busy_mid_mul", W'(busy), W'(1));
    Signal = MFLO;
    repeat (6) @(negedge clk);
    start  = 1'b1;
    Signal = DIVU;
    dataA  = 32'd1000;
    dataB  = 32'd3;
    @(negedge clk);
    start  = 1'b0;
    Signal = MFLO;
    dataA  = '0;
    dataB  = '0;
    wait_done(lat, bcnt);
    check("ignored_start_latency", W'(lat), W'(22));
    check("mflo_15", dataOut, 32'd15);

    // Reset in the middle of a divide.
    @(negedge clk);
    issue(DIVU, 32'd1000, 32'd10, 1'b0, W'(0), W'(0));
    repeat (15) @(negedge clk);
    check("busy_before_abort", W'(busy), W'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_hi", hi, W'(0));
    check("abort_lo", lo, W'(0));
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_still_idle", W'(busy), W'(0));

    issue(MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    wait_done(lat, bcnt);
    check("post_abort_latency", W'(lat), W'(33));

    // Back-to-back: start accepted during the DONE cycle.
    issue(MULTU, 32'd4, 32'd4, 1'b1, 32'd0, 32'd16);
    check("b2b_busy", W'(busy), W'(1));
    wait_done(lat, bcnt);
    check("b2b_latency", W'(lat), W'(33));
    check("mflo_16", dataOut, 32'd16);

    @(negedge clk);
    check("sb_empty", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle unsigned multiply/divide unit for the MIPS pipeline, alongside the single-cycle ALU in the EX stage. It accepts the same `dataA`/`dataB` operands and 6-bit funct-coded `Signal` that the ALU receives. It runs MULTU/DIVU iteratively into internal HI/LO registers and returns them through `dataOut` on MFHI/MFLO. The hazard unit stalls the pipeline on `busy`.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH
- MULTU, 6'b011001 (25), funct code: unsigned multiply
- DIVU, 6'b011011 (27), funct code: unsigned divide
- MFHI, 6'b010000 (16), funct code: read HI
- MFLO, 6'b010010 (18), funct code: read LO

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; low at a rising edge resets the unit
- start  in  1  request to begin the operation selected by `Signal`
- Signal  in  6  funct code
- dataA  in  WIDTH  multiplicand / dividend
- dataB  in  WIDTH  multiplier / divisor
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when HI/LO have just been updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- dataOut  out  WIDTH  combinational read-back: `hi` if Signal==MFHI, `lo` if Signal==MFLO, else 0

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE:** `start`=1 with Signal==MULTU goes to MUL; with Signal==DIVU goes to DIV. On acceptance, latch `dataA`/`dataB` and clear the iteration counter. `start` with any other Signal is ignored.
- **MUL (shift-add):** 2·WIDTH-bit accumulator.
  - Each cycle, if multiplier bit 0 = 1, add the multiplicand to the upper half using a WIDTH+1-bit sum that keeps the carry.
  - Then shift the accumulator right by 1.
  - After WIDTH iterations, upper half goes to `hi` and lower half to `lo`.
- **DIV (restoring):** each cycle, shift the {remainder, quotient} pair left by 1.
  - Trial remainder − divisor; if the result is non-negative, keep it and set quotient bit 0 = 1; else restore.
  - After WIDTH iterations, quotient goes to `lo` and remainder goes to `hi`.
- **Divide by zero:** not special-cased; the algorithm naturally yields `lo`=all ones and `hi`=dataA.
- **DONE:** one cycle with `done`=1 and `busy`=0, then IDLE. A `start` seen in DONE is accepted exactly as in IDLE.
- `start` while in MUL or DIV is ignored; latched operands are unaffected.
- `hi`/`lo` change only on completion or reset. MFHI/MFLO during `busy` return the previous results.
- All arithmetic is unsigned and modulo 2^WIDTH per register; no overflow flag.

## Timing
- Reset (`reset`=0 at an edge): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. Reset aborts any operation in progress and no partial result is written.
- `start` accepted at edge E0 → `busy`=1 from E0 until E0+WIDTH.
- The last iteration and the `hi`/`lo` write occur at edge E0+WIDTH.
- During the cycle after E0+WIDTH: `done`=1, `busy`=0, new `hi`/`lo` visible. Latency is WIDTH+1 cycles from the start edge to the `done` cycle (33 for WIDTH=32).
- Back-to-back: a `start` accepted at the edge ending the DONE cycle begins immediately; `done` never stays high for two consecutive cycles for one operation.
- `dataOut` is purely combinational from `Signal`, `hi` and `lo`.

## Test plan
- Reset low 2 cycles, then high → `hi`=`lo`=0, `busy`=`done`=0. MULTU 7×6 → `busy` 32 cycles, `done` pulse in cycle 33, `lo`=42, `hi`=0; MFLO gives `dataOut`=42.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001 (carry path).
- DIVU 100/7 → `lo`=14, `hi`=2. DIVU 0x12345678/0 → `lo`=0xFFFFFFFF, `hi`=0x12345678.
- During MULTU 3×5, pulse `start` with DIVU at cycle 10 and change `dataA`/`dataB` → ignored; result `lo`=15. MFHI read at cycle 5 returns the prior `hi`.
- Start DIVU, drive `reset` low at cycle 16 → next cycle `busy`=0, `hi`=`lo`=0, no `done`. Then a new MULTU 2×3 completes normally with `lo`=6.
- `start` in the DONE cycle with MULTU 4×4 → accepted; second `done` arrives 33 cycles later with `lo`=16.
